// File: rtl/readout_tx_pulse_generator.sv
// Readout TX pulse generator: plays a stored complex-free (real) envelope scaled by a
// signed Q1.x amplitude, framing the burst with meas_start/meas_end for the RX chain.
module readout_tx_pulse_generator #(
    parameter int DATA_WIDTH     = 8,
    parameter int ENV_ADDR_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      env_wr_en,
    input  logic [ENV_ADDR_WIDTH-1:0] env_wr_addr,
    input  logic [DATA_WIDTH-1:0]     env_wr_data,
    input  logic                      cfg_wr_en,
    input  logic                      cfg_wr_addr,
    input  logic [DATA_WIDTH-1:0]     cfg_wr_data,
    input  logic                      trigger,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_valid,
    output logic                      meas_start,
    output logic                      meas_end,
    output logic                      busy
);

    localparam int LEN_W  = ENV_ADDR_WIDTH + 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int DEPTH  = 1 << ENV_ADDR_WIDTH;

    localparam logic [LEN_W-1:0]         MAX_LEN = {1'b1, {ENV_ADDR_WIDTH{1'b0}}};
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [LEN_W-1:0]             r_pulseLength;
    logic [DATA_WIDTH-1:0]        r_ampScale;
    logic [LEN_W-1:0]             r_shadowLen;
    logic signed [DATA_WIDTH-1:0] r_shadowScale;
    logic [LEN_W-1:0]             r_rdAddr;

    logic [DATA_WIDTH-1:0]        r_envMem [DEPTH];
    logic signed [DATA_WIDTH-1:0] r_memData;

    logic                         r_s1Valid;
    logic                         r_s1First;
    logic                         r_s1Last;
    logic signed [PROD_W-1:0]     r_product;
    logic                         r_s2Valid;
    logic                         r_s2First;
    logic                         r_s2Last;

    logic [DATA_WIDTH-1:0]        r_txData;
    logic                         r_txValid;
    logic                         r_measStart;
    logic                         r_measEnd;
    logic                         r_busy;

    logic                         w_accept;
    logic                         w_issue;
    logic                         w_lastIssue;
    logic [LEN_W-1:0]             w_cfgLen;
    logic [LEN_W-1:0]             w_cfgLenClamped;
    logic signed [PROD_W-1:0]     w_envExt;
    logic signed [PROD_W-1:0]     w_scaleExt;
    logic signed [PROD_W-1:0]     w_shifted;
    logic [DATA_WIDTH-1:0]        w_sat;

    assign w_cfgLen        = cfg_wr_data[LEN_W-1:0];
    assign w_cfgLenClamped = (w_cfgLen > MAX_LEN) ? MAX_LEN : w_cfgLen;

    // A trigger coinciding with meas_end is taken so pulses can run back to back.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_lastIssue = 1'b0;
        case (r_state)
            IDLE: begin
                if (trigger && (r_pulseLength != '0) && (!r_busy || r_measEnd)) begin
                    w_accept    = 1'b1;
                    w_nextState = PLAY;
                end
            end
            PLAY: begin
                w_issue = 1'b1;
                if (r_rdAddr == (r_shadowLen - LEN_W'(1))) begin
                    w_lastIssue = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Envelope RAM is never reset; a same-address write returns the old word.
    always_ff @(posedge clk) begin
        if (env_wr_en) begin
            r_envMem[env_wr_addr] <= env_wr_data;
        end
        r_memData <= r_envMem[r_rdAddr[ENV_ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulseLength <= '0;
            r_ampScale    <= '0;
            r_shadowLen   <= '0;
            r_shadowScale <= '0;
            r_rdAddr      <= '0;
        end else begin
            if (cfg_wr_en) begin
                if (cfg_wr_addr == 1'b0) begin
                    r_pulseLength <= w_cfgLenClamped;
                end else begin
                    r_ampScale <= cfg_wr_data;
                end
            end
            if (w_accept) begin
                r_shadowLen   <= r_pulseLength;
                r_shadowScale <= r_ampScale;
                r_rdAddr      <= '0;
            end else if (w_issue) begin
                r_rdAddr <= r_rdAddr + LEN_W'(1);
            end
        end
    end

    assign w_envExt   = PROD_W'(r_memData);
    assign w_scaleExt = PROD_W'(r_shadowScale);
    assign w_shifted  = r_product >>> (DATA_WIDTH - 1);

    always_comb begin
        w_sat = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    // Pipeline: address issue -> RAM read -> multiply -> saturate/output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid   <= 1'b0;
            r_s1First   <= 1'b0;
            r_s1Last    <= 1'b0;
            r_product   <= '0;
            r_s2Valid   <= 1'b0;
            r_s2First   <= 1'b0;
            r_s2Last    <= 1'b0;
            r_txData    <= '0;
            r_txValid   <= 1'b0;
            r_measStart <= 1'b0;
            r_measEnd   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_s1Valid   <= w_issue;
            r_s1First   <= w_issue && (r_rdAddr == '0);
            r_s1Last    <= w_lastIssue;
            r_product   <= w_envExt * w_scaleExt;
            r_s2Valid   <= r_s1Valid;
            r_s2First   <= r_s1Valid && r_s1First;
            r_s2Last    <= r_s1Valid && r_s1Last;
            r_txValid   <= r_s2Valid;
            r_txData    <= r_s2Valid ? w_sat : '0;
            r_measStart <= r_s2Valid && r_s2First;
            r_measEnd   <= r_s2Valid && r_s2Last;
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_measEnd) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign tx_data    = r_txData;
    assign tx_valid   = r_txValid;
    assign meas_start = r_measStart;
    assign meas_end   = r_measEnd;
    assign busy       = r_busy;

endmodule
